// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with
// registered sync, blanking and coordinate outputs, plus an optional output delay.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 128,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 9,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 28,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 11,
  parameter int DELAY     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic             hsync,
  output logic             vsync,
  output logic             activevideo,
  output logic [CNT_W-1:0] x_px,
  output logic [CNT_W-1:0] y_px,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;

  if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_err_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : g_err_zero
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (DELAY < 0 || DELAY > 3) begin : g_err_delay
    $error("vga_timing_gen: DELAY must be 0..3");
  end

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_HS_BEG   = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] C_HS_END   = CNT_W'(H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] C_VS_BEG   = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] C_VS_END   = CNT_W'(V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] C_H_BLANK  = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] C_V_BLANK  = CNT_W'(V_BLANK);

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             act;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             ls;
    logic             fs;
    logic             vb;
  } out_t;

  localparam out_t C_OUT_RST = '{hs: ~HS_ON, vs: ~VS_ON, act: 1'b0, x: '0, y: '0,
                                 ls: 1'b0, fs: 1'b0, vb: 1'b1};

  logic [CNT_W-1:0] r_hc;
  logic [CNT_W-1:0] r_vc;
  out_t             w_nxt;
  out_t             r_pipe [DELAY+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (ce) begin
      if (r_hc == C_H_LAST) begin
        r_hc <= '0;
        r_vc <= (r_vc == C_V_LAST) ? '0 : r_vc + CNT_W'(1);
      end else begin
        r_hc <= r_hc + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_nxt     = C_OUT_RST;
    w_nxt.hs  = (r_hc >= C_HS_BEG && r_hc < C_HS_END) ? HS_ON : ~HS_ON;
    w_nxt.vs  = (r_vc >= C_VS_BEG && r_vc < C_VS_END) ? VS_ON : ~VS_ON;
    w_nxt.act = (r_hc >= C_H_BLANK) && (r_vc >= C_V_BLANK);
    if (w_nxt.act) begin
      w_nxt.x = r_hc - C_H_BLANK;
      w_nxt.y = r_vc - C_V_BLANK;
    end
    w_nxt.ls  = (r_hc == C_H_BLANK) && (r_vc >= C_V_BLANK);
    w_nxt.fs  = (r_hc == C_H_BLANK) && (r_vc == C_V_BLANK);
    w_nxt.vb  = (r_vc < C_V_BLANK);
  end

  // Stage 0 samples the counters; further stages shift the whole bundle so
  // every output sees the same latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe[0] <= C_OUT_RST;
    end else if (ce) begin
      r_pipe[0] <= w_nxt;
    end
  end

  for (genvar g = 1; g <= DELAY; g++) begin : g_dly
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pipe[g] <= C_OUT_RST;
      end else if (ce) begin
        r_pipe[g] <= r_pipe[g-1];
      end
    end
  end

  assign hsync       = r_pipe[DELAY].hs;
  assign vsync       = r_pipe[DELAY].vs;
  assign activevideo = r_pipe[DELAY].act;
  assign x_px        = r_pipe[DELAY].x;
  assign y_px        = r_pipe[DELAY].y;
  assign line_start  = r_pipe[DELAY].ls;
  assign frame_start = r_pipe[DELAY].fs;
  assign vblank      = r_pipe[DELAY].vb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (DELAY=0 active-low, DELAY=2 active-high)
// on a small raster, checked every clock against an index-based raster model.
module tb_vga_timing_gen;

  localparam int HA  = 10;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HBP = 4;
  localparam int VA  = 6;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HBL = HF + HS + HBP;
  localparam int VBL = VF + VS + VBP;
  localparam int HT  = HBL + HA;
  localparam int VT  = VBL + VA;
  localparam int FR  = HT * VT;
  localparam int CW  = 11;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic hs0, vs0, act0, ls0, fs0, vb0;
  logic [CW-1:0] x0, y0;
  logic hs2, vs2, act2, ls2, fs2, vb2;
  logic [CW-1:0] x2, y2;

  int n_checks = 0;
  int n_err    = 0;
  int k        = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(0), .VSYNC_POL(0), .CNT_W(CW), .DELAY(0)
  ) u_d0 (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hs0), .vsync(vs0), .activevideo(act0), .x_px(x0), .y_px(y0),
    .line_start(ls0), .frame_start(fs0), .vblank(vb0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(CW), .DELAY(2)
  ) u_d2 (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hs2), .vsync(vs2), .activevideo(act2), .x_px(x2), .y_px(y2),
    .line_start(ls2), .frame_start(fs2), .vblank(vb2)
  );

  typedef struct {
    int hs, vs, act, x, y, ls, fs, vb;
  } exp_t;

  // idx = raster position (pixels since reset) whose values should be on the
  // outputs; negative means nothing has reached the outputs yet.
  function automatic exp_t model(input int idx, input int hp, input int vp);
    exp_t e;
    int hc, vc;
    e.hs = hp ? 0 : 1;
    e.vs = vp ? 0 : 1;
    e.act = 0; e.x = 0; e.y = 0; e.ls = 0; e.fs = 0; e.vb = 1;
    if (idx >= 0) begin
      hc = idx % HT;
      vc = (idx / HT) % VT;
      e.hs  = (hc >= HF && hc < HF + HS) ? hp : (hp ? 0 : 1);
      e.vs  = (vc >= VF && vc < VF + VS) ? vp : (vp ? 0 : 1);
      e.act = (hc >= HBL && vc >= VBL) ? 1 : 0;
      if (e.act != 0) begin
        e.x = hc - HBL;
        e.y = vc - VBL;
      end
      e.ls = (hc == HBL && vc >= VBL) ? 1 : 0;
      e.fs = (hc == HBL && vc == VBL) ? 1 : 0;
      e.vb = (vc < VBL) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", tag, got, exp, $time, k);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = model(k - 1, 0, 0);
    chk("d0.hsync", hs0, e.hs);  chk("d0.vsync", vs0, e.vs);
    chk("d0.act", act0, e.act);  chk("d0.x", x0, e.x);  chk("d0.y", y0, e.y);
    chk("d0.line_start", ls0, e.ls); chk("d0.frame_start", fs0, e.fs);
    chk("d0.vblank", vb0, e.vb);
    e = model(k - 3, 1, 1);
    chk("d2.hsync", hs2, e.hs);  chk("d2.vsync", vs2, e.vs);
    chk("d2.act", act2, e.act);  chk("d2.x", x2, e.x);  chk("d2.y", y2, e.y);
    chk("d2.line_start", ls2, e.ls); chk("d2.frame_start", fs2, e.fs);
    chk("d2.vblank", vb2, e.vb);
  endtask

  // Called at a falling edge: drive inputs, run one rising edge, check.
  task automatic step(input logic ce_v, input logic rst_v);
    ce    = ce_v;
    reset = rst_v;
    if (rst_v) begin
      k = 0;
      #1;
      check_all();
    end
    @(posedge clk);
    if (!reset && ce) k++;
    @(negedge clk);
    check_all();
  endtask

  int cnt_act, cnt_fs, cnt_fs00, cnt_hs, cnt_vs, cnt_last;
  int cyc, last_onset;
  logic prev_hs;

  initial begin
    ce    = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all();

    // continuous ce: whole-frame totals over a two-frame window
    cnt_act = 0; cnt_fs = 0; cnt_fs00 = 0; cnt_hs = 0; cnt_vs = 0; cnt_last = 0;
    for (int i = 0; i < 10 + 2 * FR; i++) begin
      step(1'b1, 1'b0);
      if (i >= 10) begin
        if (act0) cnt_act++;
        if (fs0) cnt_fs++;
        if (fs0 && x0 == 0 && y0 == 0) cnt_fs00++;
        if (!hs0) cnt_hs++;
        if (!vs0) cnt_vs++;
        if (act0 && x0 == CW'(HA - 1) && y0 == CW'(VA - 1)) cnt_last++;
      end
    end
    chk("active_per_2frames", cnt_act, 2 * HA * VA);
    chk("frame_start_per_2frames", cnt_fs, 2);
    chk("frame_start_at_origin", cnt_fs00, 2);
    chk("hsync_low_clks", cnt_hs, 2 * VT * HS);
    chk("vsync_low_clks", cnt_vs, 2 * VS * HT);
    chk("last_pixel_seen", cnt_last, 2);

    // ce toggling 1,0: hsync period doubles
    cyc = 0; last_onset = -1; prev_hs = hs0;
    for (int i = 0; i < 8 * HT; i++) begin
      step((i % 2) == 0, 1'b0);
      cyc++;
      if (prev_hs && !hs0) begin
        if (last_onset >= 0) chk("hsync_period_half_ce", cyc - last_onset, 2 * HT);
        last_onset = cyc;
      end
      prev_hs = hs0;
    end

    // mid-frame reset, then hsync onset 1+H_FP enabled cycles after release
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    cyc = 0; last_onset = -1;
    for (int i = 0; i < 3 * HT && last_onset < 0; i++) begin
      step(1'b1, 1'b0);
      cyc++;
      if (!hs0) last_onset = cyc;
    end
    chk("hsync_onset_after_reset", last_onset, 1 + HF);

    // random ce with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) step($urandom_range(0, 1) != 0, 1'b1);
      end
      step($urandom_range(0, 3) != 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
